// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: op codes, FSM states and special-result
// constants shared by the execute unit and its tests.
package alu_mdu_pkg;

  localparam int unsigned MAXW = 64;

  localparam logic [4:0] ALU_ADD   = 5'h00;
  localparam logic [4:0] ALU_SUB   = 5'h01;
  localparam logic [4:0] ALU_AND   = 5'h02;
  localparam logic [4:0] ALU_OR    = 5'h03;
  localparam logic [4:0] ALU_XOR   = 5'h04;
  localparam logic [4:0] ALU_SLL   = 5'h05;
  localparam logic [4:0] ALU_SRL   = 5'h06;
  localparam logic [4:0] ALU_SRA   = 5'h07;
  localparam logic [4:0] ALU_SLT   = 5'h08;
  localparam logic [4:0] ALU_SLTU  = 5'h09;
  localparam logic [4:0] ALU_PASSB = 5'h0A;
  localparam logic [4:0] ALU_EQ    = 5'h10;
  localparam logic [4:0] ALU_NE    = 5'h11;
  localparam logic [4:0] ALU_LTS   = 5'h12;
  localparam logic [4:0] ALU_LTU   = 5'h13;
  localparam logic [4:0] ALU_GES   = 5'h14;
  localparam logic [4:0] ALU_GEU   = 5'h15;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [MAXW-1:0] ALL_ONES = '1;

  // signed minimum of a w-bit word, zero-extended
  function automatic logic [MAXW-1:0] smin(input int unsigned w);
    return {{(MAXW-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one-bit-per-cycle shift/add multiply and
// restoring divide on unsigned magnitudes, 2N-bit accumulator.
module mdu_iter_core #(
  parameter int N    = 32,
  parameter int LOGN = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           clr,
  input  logic           div_mode,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [2*N-1:0] acc_nxt,
  output logic           last
);

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [N:0]     sum;
  logic [N:0]     rem_t;
  logic [N:0]     diff;

  assign last = (cnt_q == LOGN'(N - 1));

  // one iteration: mul adds then shifts right,
  // div shifts left then trial-subtracts
  always_comb begin
    sum     = {1'b0, acc_q[2*N-1:N]}
            + {1'b0, opb_q & {N{acc_q[0]}}};
    rem_t   = acc_q[2*N-1:N-1];
    diff    = rem_t - {1'b0, opb_q};
    if (!div_mode) begin
      acc_nxt = {sum, acc_q[N-1:1]};
    end else if (!diff[N]) begin
      acc_nxt = {diff[N-1:0], acc_q[N-2:0], 1'b1};
    end else begin
      acc_nxt = {rem_t[N-1:0], acc_q[N-2:0], 1'b0};
    end
  end

  // load operands, advance or abort the iteration
  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      acc_d = {{N{1'b0}}, op_a};
      opb_d = op_b;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + LOGN'(1);
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: base ALU plus RV32M execute unit, Start/Busy/Valid.
// ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier.
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(
  parameter int N    = 32,
  parameter int LOGN = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Start,
  input  logic         Flush,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   ALUOp,
  input  logic         MdSel,
  input  logic [2:0]   MdOp,
  output logic         Busy,
  output logic         Valid,
  output logic [N-1:0] Result,
  output logic         Flag
);

  localparam logic [MAXW-1:0] SMIN_W = smin(N);
  localparam logic [N-1:0]    SMIN   = SMIN_W[N-1:0];
  localparam logic [N-1:0]    ONES   = ALL_ONES[N-1:0];

  state_e         state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  logic           flag_q, flag_d;
  logic           valid_q, valid_d;
  logic           neg_q, neg_d;
  logic           hi_q, hi_d;
  logic           rem_q, rem_d;
  logic           div_q, div_d;

  md_op_e         md_op;
  logic           is_mul;
  logic           a_sgn, b_sgn;
  logic           a_neg, b_neg;
  logic [N-1:0]   mag_a, mag_b;
  logic           div_zero, div_ovf;
  logic [N-1:0]   sp_res;
  logic [N-1:0]   alu_res;
  logic           alu_flg;
  logic [LOGN-1:0] shamt;
  logic           load, step, clr;
  logic [2*N-1:0] acc_nxt;
  logic           last;
  logic [2*N-1:0] mul_p;
  logic [N-1:0]   quo, rmd;
  logic [N-1:0]   fin_res;

  assign md_op  = md_op_e'(MdOp);
  assign is_mul = ~MdOp[2];
  assign shamt  = B[LOGN-1:0];

  assign Busy   = (state_q != ST_IDLE);
  assign Valid  = valid_q;
  assign Result = result_q;
  assign Flag   = flag_q;

  // operand signedness per M op
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      md_op == MD_MULH,
      md_op == MD_DIV,
      md_op == MD_REM:    begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      md_op == MD_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_sgn & A[N-1];
  assign b_neg = b_sgn & B[N-1];
  assign mag_a = a_neg ? -A : A;
  assign mag_b = b_neg ? -B : B;

  assign div_zero = ~|B;
  assign div_ovf  = (A == SMIN) && (&B)
                  && ((md_op == MD_DIV) || (md_op == MD_REM));
  // REM/REMU have funct3[1] set
  assign sp_res   = div_zero ? (MdOp[1] ? A : ONES)
                             : (MdOp[1] ? '0 : A);

  // base ALU: result-class and flag-class ops
  always_comb begin
    alu_res = '0;
    alu_flg = 1'b0;
    unique case (ALUOp)
      ALU_ADD:   alu_res = A + B;
      ALU_SUB:   alu_res = A - B;
      ALU_AND:   alu_res = A & B;
      ALU_OR:    alu_res = A | B;
      ALU_XOR:   alu_res = A ^ B;
      ALU_SLL:   alu_res = A << shamt;
      ALU_SRL:   alu_res = A >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(A) >>> shamt);
      ALU_SLT:   alu_res = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU:  alu_res = {{(N-1){1'b0}}, A < B};
      ALU_PASSB: alu_res = B;
      ALU_EQ:    alu_flg = (A == B);
      ALU_NE:    alu_flg = (A != B);
      ALU_LTS:   alu_flg = ($signed(A) < $signed(B));
      ALU_LTU:   alu_flg = (A < B);
      ALU_GES:   alu_flg = ($signed(A) >= $signed(B));
      ALU_GEU:   alu_flg = (A >= B);
      default: ;
    endcase
  end

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*N-1:0] fast_mag;
  logic [2*N-1:0] fast_p;
  logic [N-1:0]   fast_res;

  assign fast_mag = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
  assign fast_p   = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  assign fast_res = (md_op == MD_MUL) ? fast_p[N-1:0]
                                      : fast_p[2*N-1:N];
`endif

  // sign post-processing of the final iteration
  always_comb begin
    mul_p = neg_q ? -acc_nxt : acc_nxt;
    quo   = acc_nxt[N-1:0];
    rmd   = acc_nxt[2*N-1:N];
    if (!div_q) begin
      fin_res = hi_q ? mul_p[2*N-1:N] : mul_p[N-1:0];
    end else if (rem_q) begin
      fin_res = neg_q ? -rmd : rmd;
    end else begin
      fin_res = neg_q ? -quo : quo;
    end
  end

  // next state, output updates and datapath control
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = 1'b0;
    neg_d    = neg_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    div_d    = div_q;
    load     = 1'b0;
    step     = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!Flush && Start) begin
          if (!MdSel) begin
            result_d = alu_res;
            flag_d   = alu_flg;
            valid_d  = 1'b1;
          end else if (is_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
            result_d = fast_res;
            flag_d   = 1'b0;
            valid_d  = 1'b1;
`else
            load     = 1'b1;
            state_d  = ST_ITER;
`endif
          end else if (div_zero || div_ovf) begin
            result_d = sp_res;
            flag_d   = 1'b0;
            valid_d  = 1'b1;
          end else begin
            load     = 1'b1;
            state_d  = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (Flush) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            result_d = fin_res;
            flag_d   = 1'b0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      div_d = MdOp[2];
      hi_d  = (md_op != MD_MUL);
      rem_d = MdOp[1];
      neg_d = (MdOp[2] & MdOp[1]) ? a_neg : (a_neg ^ b_neg);
    end
  end

  // FSM, output and sign-control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      rem_q    <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
    end
  end

  mdu_iter_core #(
    .N    (N),
    .LOGN (LOGN)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .clr      (clr),
    .div_mode (div_q),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .acc_nxt  (acc_nxt),
    .last     (last)
  );

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: scoreboard bench for alu_mdu_seq,
// reference model for base and M ops.
module tb_alu_mdu_seq;
  import alu_mdu_pkg::*;

  localparam int N    = 32;
  localparam int LOGN = 5;
`ifdef ALU_MDU_FAST_MUL_EN
  localparam int LM = 1;
`else
  localparam int LM = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [4:0]   ALUOp = '0;
  logic         MdSel = 1'b0;
  logic [2:0]   MdOp = '0;
  logic         Busy;
  logic         Valid;
  logic [N-1:0] Result;
  logic         Flag;

  typedef struct {
    logic [N-1:0] res;
    logic         flg;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  logic [4:0] codes [17] = '{
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_PASSB, ALU_EQ, ALU_NE, ALU_LTS, ALU_LTU,
    ALU_GES, 5'h1F
  };

  alu_mdu_seq #(.N(N), .LOGN(LOGN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Flush  (Flush),
    .A      (A),
    .B      (B),
    .ALUOp  (ALUOp),
    .MdSel  (MdSel),
    .MdOp   (MdOp),
    .Busy   (Busy),
    .Valid  (Valid),
    .Result (Result),
    .Flag   (Flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [4:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic f);
    r = '0;
    f = 1'b0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: r = b;
      ALU_EQ:    f = (a == b);
      ALU_NE:    f = (a != b);
      ALU_LTS:   f = ($signed(a) < $signed(b));
      ALU_LTU:   f = (a < b);
      ALU_GES:   f = !($signed(a) < $signed(b));
      ALU_GEU:   f = !(a < b);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
      3'd1: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp[63:32];
      end
      3'd2: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
        return sp[63:32];
      end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_md(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (!op[2]) return LM;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return N + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (Busy) busy_cnt++;
    if (Valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq({mon_e.tag, "_res"}, Result, mon_e.res);
        check_eq({mon_e.tag, "_flag"}, Flag, mon_e.flg);
        check_eq({mon_e.tag, "_lat"}, cyc, mon_e.due);
      end
    end
  end

  // drive one Start pulse; called just after a rising edge
  task automatic issue(input logic md, input logic [4:0] aop,
                       input logic [2:0] mop,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic push, input logic [N-1:0] er,
                       input logic ef, input int lat,
                       input string tag);
    exp_t e;
    Start = 1'b1;
    MdSel = md;
    ALUOp = aop;
    MdOp  = mop;
    A     = a;
    B     = b;
    if (push) begin
      e.res = er;
      e.flg = ef;
      e.due = cyc + lat;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || Busy) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      check_eq({tag, "_timeout"}, sb.size(), 64'd0);
      sb.delete();
    end
  endtask

  task automatic md_op(input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input string tag);
    issue(1'b1, 5'h0, op, a, b, 1'b1, er, 1'b0,
          lat_md(op, a, b), tag);
    drain(tag);
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic        rf;
    logic [4:0]  aop;
    logic [2:0]  mop;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_valid", Valid, 0);
    check_eq("rst_result", Result, 0);
    check_eq("rst_flag", Flag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, ALU_ADD, 3'd0, 32'h7FFF_FFFF, 32'h1,
          1'b1, 32'h8000_0000, 1'b0, 1, "add");
    check_eq("add_busy", Busy, 0);
    drain("add");
    issue(1'b0, ALU_LTS, 3'd0, 32'hFFFF_FFFF, 32'h1,
          1'b1, 32'h0, 1'b1, 1, "lts");
    drain("lts");
    issue(1'b0, ALU_LTU, 3'd0, 32'hFFFF_FFFF, 32'h1,
          1'b1, 32'h0, 1'b0, 1, "ltu");
    drain("ltu");

    busy_cnt = 0;
    md_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    check_eq("mulh_busy_cycles", busy_cnt, (LM == 1) ? 0 : 33);
    md_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu");
    md_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, "mul");
    md_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");

    md_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, "div_m7_2");
    md_op(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, "rem_m7_2");
    issue(1'b1, 5'h0, 3'd4, 32'h1234, 32'h0,
          1'b1, 32'hFFFF_FFFF, 1'b0, 1, "div_zero");
    check_eq("div_zero_busy", Busy, 0);
    drain("div_zero");
    md_op(3'd7, 32'h1234, 32'h0, 32'h1234, "remu_zero");
    md_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
    md_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");

    // flush mid-divide: no Valid, Result holds
    issue(1'b1, 5'h0, 3'd5, 32'd100, 32'd7,
          1'b0, 32'h0, 1'b0, 0, "divu_fl");
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check_eq("flush_busy", Busy, 0);
    check_eq("flush_hold", Result, 32'h8000_0000);
    md_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_after_fl");

    // flush beats a simultaneous start
    Flush = 1'b1;
    issue(1'b1, 5'h0, 3'd5, 32'd9, 32'd3,
          1'b0, 32'h0, 1'b0, 0, "fl_prio");
    Flush = 1'b0;
    check_eq("flush_prio_busy", Busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // async reset in the middle of a multiply
    issue(1'b1, 5'h0, 3'd0, 32'd3, 32'd5,
          1'b0, 32'h0, 1'b0, 0, "mul_rst");
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", Busy, 0);
    check_eq("midrst_valid", Valid, 0);
    check_eq("midrst_result", Result, 0);
    check_eq("midrst_flag", Flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // starts while busy and during DONE are dropped
    issue(1'b1, 5'h0, 3'd0, 32'd1234, 32'd5678,
          1'b1, 32'd7006652, 1'b0, LM, "mul_busy");
    if (LM > 1) begin
      repeat (3) @(posedge clk);
      #1;
      Start = 1'b1;
      MdOp  = 3'd5;
      A     = 32'd99;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (28) @(posedge clk);
      #1;
      Start = 1'b1;
      MdOp  = 3'd5;
      @(posedge clk); #1;
      Start = 1'b0;
    end
    drain("mul_busy");
    repeat (40) @(posedge clk);
    #1;

    // random mix against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        aop = codes[$urandom_range(0, 16)];
        ref_alu(aop, ra, rb, rr, rf);
        issue(1'b0, aop, 3'd0, ra, rb, 1'b1, rr, rf, 1, "rnd_alu");
        drain("rnd_alu");
      end else begin
        mop = 3'($urandom_range(0, 7));
        if (i % 7 == 1) rb = 32'h0;
        if (i % 11 == 3) begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        md_op(mop, ra, rb, ref_md(mop, ra, rb), "rnd_md");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Next-generation execute unit for the single-cycle RISC-V core: the base ALU function set plus the RV32M multiply/divide set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Multi-cycle, with a Start/Busy/Valid handshake. The core stalls on Busy.
- Base ops complete in 1 cycle; multiply and divide are iterative, one bit per cycle.
- Result and Flag are registered.

Parameters:
- N, 32: operand/result width; must be even, >= 4.
- LOGN, 5: log2(N); shift-amount width and iteration-counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  launch an op; sampled only when Busy=0.
- Flush  in  1  synchronous abort of an in-flight op.
- A  in  N  operand 1 (rs1).
- B  in  N  operand 2 (rs2/imm).
- ALUOp  in  5  base op code; shared encoding with the base ALU.
- MdSel  in  1  1 = M-extension op selected by MdOp; ALUOp ignored.
- MdOp  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Busy  out  1  iterative op in progress.
- Valid  out  1  one-cycle pulse; Result/Flag updated this cycle.
- Result  out  N  registered result.
- Flag  out  1  registered branch-compare flag.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset values: Busy=0, Valid=0, Result=0, Flag=0; FSM in IDLE; iteration counter 0.
- FSM states: IDLE, ITER, DONE.

Base ops (MdSel=0):
- Start in IDLE → Result/Flag registered at the next edge, Valid=1 that cycle. Busy never rises.
- Result-class ops (ALUOp[4]=0) force Flag=0. Flag-class ops (ALUOp[4]=1) force Result=0.
- Shifts use B[LOGN-1:0]. Undefined ALUOp codes → Result=0, Flag=0, Valid still pulses.

Multiply (MdSel=1, MdOp 0-3):
- IDLE→ITER. Operands latched, converted to magnitudes per signedness: MULH signed×signed; MULHSU signed×unsigned; MULHU and MUL unsigned.
- Shift-add over N cycles into a 2N-bit accumulator.
- Then DONE: apply sign correction (two's-complement negate of 2N bits), output low half (MUL) or high half (MULH*). Valid=1 in DONE, then IDLE.
- Latency Start→Valid = N+1 cycles. Busy=1 from the cycle after Start through DONE inclusive.

Divide (MdOp 4-7):
- Restoring division on magnitudes over N cycles.
- DONE applies signs: quotient negated iff operand signs differ; remainder takes the dividend's sign.
- Latency N+1 cycles.
- Divide by zero is detected at Start, bypasses ITER, latency 1, Busy stays 0:
  - DIV/DIVU → all-ones; REM/REMU → A.
- Signed overflow (A = 0x8000_0000, B = -1, DIV/REM) is handled the same way, latency 1:
  - DIV → A; REM → 0.
- Flag=0 for all M ops.

Handshake and boundary conditions:
- Start while Busy=1 is ignored; no queueing.
- Start in the same cycle as DONE is ignored. The next Start is accepted the cycle after Valid.
- Flush=1: any state → IDLE at the next edge, Busy=0, no Valid, Result/Flag hold their last values.
- Flush has priority over Start in the same cycle.
- Async reset mid-ITER: immediate return to the reset values above.
- Operands are latched at Start; A/B may change during ITER without effect.
- Arithmetic is N-bit wrap-around for ADD/SUB; the carry-out is discarded.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2N-bit combinational product with latency 1 (like the base ops). Busy never rises for multiply. Divide is unchanged.
- Undefined: iterative multiply as above, latency N+1.

Decomposition:
- Package alu_mdu_pkg:
  - ALU op localparams, width 5, the same codes as the base ALU.
  - md_op_e enum, 3 bits.
  - FSM state enum.
  - Special-result constants: all-ones; signed minimum.
- Sub-module mdu_iter_core:
  - Shared shift/add/subtract datapath: 2N-bit accumulator, LOGN-bit counter, mode select mul/div.
  - The top level owns the FSM, sign pre/post-processing, the base-op path and the output registers.

Test Plan:
- ADD, A=0x7FFF_FFFF, B=1 → Valid next cycle, Result=0x8000_0000, Flag=0, Busy stays 0.
- ALU_LTS, A=0xFFFF_FFFF, B=1 → Flag=1, Result=0; LTU with the same operands → Flag=0.
- MULH, A=0x8000_0000, B=0x8000_0000 → Busy high 33 cycles, Valid at Start+33, Result=0x4000_0000. MULHU with the same operands → 0x4000_0000; MUL → 0x0000_0000.
- DIV A=-7, B=2 → Result=-3 (0xFFFF_FFFD); REM → -1. DIV by B=0 → 0xFFFF_FFFF at Start+1 with Busy=0. DIV 0x8000_0000 / -1 → 0x8000_0000.
- Start DIVU, then Flush at iteration 10 → Busy falls next edge, no Valid, Result unchanged. A new Start next cycle is accepted.
- rst_n asserted low mid-MUL → outputs 0 immediately. A second Start while Busy=1 is ignored and the original op completes with the correct value.
